// File: rtl/mul_ctrl_pkg.sv
// Shared encodings for the EXE-stage multiply controller.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MUL_W   = 2'b00,
        OP_MULH_W  = 2'b01,
        OP_MULH_WU = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_ctrl_mul.sv
// Two-cycle 32x32 multiplier: product registered on the first enabled cycle,
// flagged complete on the second. The phase bit only advances while mul is high.
module Mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul,
    input  logic        mul_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] result,
    output logic        mul_complete
);

    logic        phase_q, phase_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] ext_x, ext_y;

    always_comb begin
        ext_x   = mul_signed ? {{32{x[31]}}, x} : {32'b0, x};
        ext_y   = mul_signed ? {{32{y[31]}}, y} : {32'b0, y};
        phase_d = phase_q;
        prod_d  = prod_q;
        if (mul) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                prod_d = ext_x * ext_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            phase_q <= phase_d;
            prod_q  <= prod_d;
        end
    end

    assign result       = prod_q;
    assign mul_complete = mul & phase_q;

endmodule

// File: rtl/mul_ctrl.sv
// Issue/sequence controller for the two-cycle multiplier: one µop in flight,
// registered result held until taken, flush drains the multiplier before idling.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned DEST_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [31:0]       in_src1,
    input  logic [31:0]       in_src2,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       src1_q, src1_d;
    logic [31:0]       src2_q, src2_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [31:0]       out_result_q, out_result_d;
    logic [DEST_W-1:0] out_dest_q, out_dest_d;
    logic              out_valid_q, out_valid_d;

    logic        mul_en;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic        mul_complete;

    assign mul_en     = (state_q == S_CALC);
    assign mul_signed = (op_q != OP_MULH_WU);

    Mul u_mul (
        .clk          (clk),
        .reset        (~resetn),
        .mul          (mul_en),
        .mul_signed   (mul_signed),
        .x            (src1_q),
        .y            (src2_q),
        .result       (mul_result),
        .mul_complete (mul_complete)
    );

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dest_d       = dest_q;
        out_result_d = out_result_q;
        out_dest_d   = out_dest_q;
        out_valid_d  = out_valid_q;
        in_ready     = 1'b0;

        case (state_q)
            S_IDLE: in_ready = ~flush;
            S_CALC: begin
                // mul_en stays high through a kill so the multiplier phase stays aligned
                kill_d = kill_q | flush;
                if (mul_complete) begin
                    kill_d = 1'b0;
                    if (kill_q | flush) begin
                        state_d = S_IDLE;
                    end else begin
                        out_result_d = ((op_q == OP_MULH_W) || (op_q == OP_MULH_WU))
                                       ? mul_result[63:32] : mul_result[31:0];
                        out_dest_d   = dest_q;
                        out_valid_d  = 1'b1;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flush) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    in_ready    = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready = in_ready & resetn;

        if (in_valid && in_ready) begin
            op_d    = in_op;
            src1_d  = in_src1;
            src2_d  = in_src2;
            dest_d  = in_dest;
            state_d = S_CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            op_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dest_q       <= '0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            op_q         <= op_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dest_q       <= dest_d;
            out_result_q <= out_result_d;
            out_dest_q   <= out_dest_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dest   = out_dest_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed and randomized checks of mul_ctrl against an arithmetic product model.
module tb_mul_ctrl;

    localparam int unsigned DEST_W = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [31:0]       in_src1;
    logic [31:0]       in_src2;
    logic [DEST_W-1:0] in_dest;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.DEST_W(DEST_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_dest    (in_dest),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .busy       (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        case (op)
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp[63:32];
            end
            2'b10: begin
                up = 64'(a) * 64'(b);
                return up[63:32];
            end
            default: return a * b;
        endcase
    endfunction

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [DEST_W-1:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_dest  = d;
    endtask

    // Starts in an idle cycle T; checks latency 3, hold under stall, and return to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [DEST_W-1:0] d,
                          input int stall, input logic [31:0] exp);
        drive_op(op, a, b, d);
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        #1;
        chk({tag, "_busy_t1"}, 64'(busy), 64'(1));
        chk({tag, "_ov_t1"}, 64'(out_valid), 64'(0));
        step();
        chk({tag, "_ov_t2"}, 64'(out_valid), 64'(0));
        step();
        chk({tag, "_ov_t3"}, 64'(out_valid), 64'(1));
        chk({tag, "_result"}, 64'(out_result), 64'(exp));
        chk({tag, "_dest"}, 64'(out_dest), 64'(d));
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_rdy"}, 64'(in_ready), 64'(0));
            step();
            chk({tag, "_stall_ov"}, 64'(out_valid), 64'(1));
            chk({tag, "_stall_res"}, 64'(out_result), 64'(exp));
        end
        out_ready = 1'b1;
        #1;
        chk({tag, "_done_rdy"}, 64'(in_ready), 64'(1));
        step();
        out_ready = 1'b0;
        #1;
        chk({tag, "_ov_after"}, 64'(out_valid), 64'(0));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    // Flush during calculation at T+when; the result must never appear.
    task automatic flush_op(input string tag, input int when);
        int en_cnt;
        en_cnt = 0;
        drive_op(2'b00, 32'd3, 32'd5, 5'd7);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            flush = (k == when);
            #1;
            en_cnt += int'(dut.mul_en);
            chk({tag, "_no_ov"}, 64'(out_valid), 64'(0));
            if (k == 3) chk({tag, "_rdy_t3"}, 64'(in_ready), 64'(1));
            step();
        end
        flush = 1'b0;
        chk({tag, "_mul_en_cycles"}, 64'(en_cnt), 64'(2));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] ba [3];
        logic [31:0] bb [3];
        int          got;
        int          idx;
        int          t0;
        logic        acc;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_dest   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_dest", 64'(out_dest), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        resetn = 1'b1;
        #1;
        chk("rst_release_rdy", 64'(in_ready), 64'(1));
        step();

        // Directed products
        run_op("mulw_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 0, 32'h0000002A);
        run_op("mulhw_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0, 32'h00000000);
        run_op("mulhwu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 0, 32'hFFFFFFFE);
        run_op("rsvd_op", 2'b11, 32'hFFFFFFFF, 32'd3, 5'd6, 1, 32'hFFFFFFFD);
        run_op("backpress", 2'b10, 32'h80000000, 32'd4, 5'd9, 4, 32'h00000002);

        // Flush during CALC, then confirm the multiplier phase is still aligned
        flush_op("flush_t1", 1);
        run_op("after_flush1", 2'b00, 32'd9, 32'd9, 5'd10, 0, 32'h00000051);
        flush_op("flush_t2", 2);
        run_op("after_flush2", 2'b00, 32'd9, 32'd9, 5'd11, 0, 32'h00000051);

        // Flush wins over out_ready in DONE
        drive_op(2'b00, 32'd5, 32'd5, 5'd12);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("fdone_ov", 64'(out_valid), 64'(1));
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("fdone_rdy", 64'(in_ready), 64'(0));
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("fdone_ov_drop", 64'(out_valid), 64'(0));
        chk("fdone_busy", 64'(busy), 64'(0));

        // Flush in IDLE blocks accept
        drive_op(2'b00, 32'd1, 32'd1, 5'd1);
        flush = 1'b1;
        #1;
        chk("fidle_rdy", 64'(in_ready), 64'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fidle_busy", 64'(busy), 64'(0));

        // Back-to-back with continuous valid/ready
        ba[0] = 32'd2;      bb[0] = 32'd3;
        ba[1] = 32'd10;     bb[1] = 32'd11;
        ba[2] = 32'h0000FFFF; bb[2] = 32'd5;
        idx = 0;
        got = 0;
        t0  = cyc;
        drive_op(2'b00, ba[0], bb[0], 5'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (out_valid) begin
                if (got < 3) begin
                    chk("b2b_result", 64'(out_result), 64'(model(2'b00, ba[got], bb[got])));
                    chk("b2b_dest", 64'(out_dest), 64'(got + 1));
                    chk("b2b_time", 64'(cyc - t0), 64'(3 * (got + 1)));
                end
                got++;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) drive_op(2'b00, ba[idx], bb[idx], DEST_W'(idx + 1));
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count", 64'(got), 64'(3));

        // Reset in the middle of an operation
        drive_op(2'b00, 32'd100, 32'd100, 5'd20);
        step();
        in_valid = 1'b0;
        step();
        resetn = 1'b0;
        step();
        chk("mrst_ov", 64'(out_valid), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_result", 64'(out_result), 64'(0));
        chk("mrst_dest", 64'(out_dest), 64'(0));
        chk("mrst_rdy", 64'(in_ready), 64'(0));
        resetn = 1'b1;
        #1;
        run_op("mrst_2x3", 2'b00, 32'd2, 32'd3, 5'd21, 0, 32'h00000006);

        // Randomized operations checked against the product model
        for (int n = 0; n < 25; n++) begin
            logic [1:0]        rop;
            logic [31:0]       ra;
            logic [31:0]       rb;
            logic [DEST_W-1:0] rd;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rd  = DEST_W'($urandom);
            run_op("rand", rop, ra, rb, rd, int'($urandom_range(0, 2)), model(rop, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
